// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates one single-port memory between an instruction-fetch port and a
//   data load/store port.
//   - A data request has fixed priority over a fetch.
//   - Address, write data, byte enables and write enable are latched at grant.
//   - The grant completes when mem_ready is seen, or aborts after TIMEOUT wait
//     cycles with zero read data and a bus_err pulse.
//   - The response state lasts one cycle and ignores new requests, so a request
//     still held during its ack is not granted again.
//
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   if_req, if_addr                fetch request / word address
//   if_rdata, if_ack               fetch data (valid with ack), completion pulse
//   d_read, d_write, d_addr,
//   d_wdata, d_be                  data load/store request, address, data, enables
//   d_rdata, d_ack                 load data (valid with ack), completion pulse
//   bus_err                        pulses with the ack of a timed-out access
//   stall                          a request is pending and not yet acknowledged
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be              registered memory request signals
//   mem_rdata, mem_ready           memory read data and completion strobe
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        bus_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, DATA, FETCH, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  wait_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_ack_q;
    logic        d_ack_q;
    logic        bus_err_q;
    logic        timeout_d;

    // Last permitted wait cycle: without mem_ready now, the access is aborted.
    always_comb begin
        timeout_d = (wait_q == WAIT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            // Acks and bus_err are single-cycle pulses, raised only on RESP entry.
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (d_read || d_write) begin
                        state_q     <= DATA;
                        wait_q      <= 8'd0;
                        mem_req_q   <= 1'b1;
                        // A simultaneous read and write is treated as a write.
                        mem_we_q    <= d_write;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_be_q    <= d_write ? d_be : 4'hF;
                    end else if (if_req) begin
                        state_q     <= FETCH;
                        wait_q      <= 8'd0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= 32'd0;
                        mem_be_q    <= 4'hF;
                    end
                end
                DATA, FETCH: begin
                    if (mem_ready || timeout_d) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        bus_err_q <= ~mem_ready;
                        if (state_q == DATA) begin
                            d_ack_q   <= 1'b1;
                            d_rdata_q <= mem_ready ? mem_rdata : 32'd0;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= mem_ready ? mem_rdata : 32'd0;
                        end
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                RESP: begin
                    // Requests are not sampled here; a held request would
                    // otherwise be granted a second time.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

    assign stall = ((d_read | d_write) & ~d_ack) | (if_req & ~if_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        bus_err;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_rdata(d_rdata), .d_ack(d_ack), .bus_err(bus_err),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_addr = 0;
        d_wdata = 0; d_be = 0; mem_rdata = 0; mem_ready = 0;
        #12;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        total++; if ({if_ack, d_ack, bus_err} !== 3'b000) begin bad++; $display("FAIL rst_acks: got %b want 000", {if_ack, d_ack, bus_err}); end
        total++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata); end
        total++; if (mem_be !== 4'd0) begin bad++; $display("FAIL rst_mem_be: got %h want 0", mem_be); end
        total++; if (if_rdata !== 32'd0 || d_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_after_rst: mem_req got %b want 0", mem_req); end
    endtask

    // Fetch of word 0x40 with a one-cycle memory.
    task automatic test_fetch(input logic [31:0] rd);
        if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = rd;   // cycle 0
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_c0: got %b want 1", stall); end
        tick();                                                           // cycle 1
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL fetch_c1: req/addr got %b/%h want 1/00000040", mem_req, mem_addr); end
        total++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin bad++; $display("FAIL fetch_c1_we_be: got %b/%h want 0/f", mem_we, mem_be); end
        tick();                                                           // cycle 2
        mem_ready = 0;
        total++; if (if_ack !== 1'b1 || if_rdata !== rd) begin bad++; $display("FAIL fetch_c2_ack: ack/rdata got %b/%h want 1/%h", if_ack, if_rdata, rd); end
        total++; if (d_ack !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL fetch_c2_other: d_ack/bus_err got %b/%b want 0/0", d_ack, bus_err); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL fetch_c2_stall: got %b want 0", stall); end
        if_req = 0;
        mem_rdata = 32'hFFFF_0000;
        tick();                                                           // cycle 3
        total++; if (if_ack !== 1'b0 || if_rdata !== rd) begin bad++; $display("FAIL fetch_c3_hold: ack/rdata got %b/%h want 0/%h", if_ack, if_rdata, rd); end
    endtask

    // Load and fetch raised together: load first, fetch granted afterwards.
    task automatic test_priority();
        d_read = 1; d_addr = 32'h200; if_req = 1; if_addr = 32'h44;
        mem_ready = 1; mem_rdata = 32'hAAAA_0001;                          // cycle 0
        tick();                                                           // cycle 1
        total++; if (mem_addr !== 32'h200 || mem_we !== 1'b0) begin bad++; $display("FAIL prio_c1: addr/we got %h/%b want 00000200/0", mem_addr, mem_we); end
        tick();                                                           // cycle 2
        total++; if (d_ack !== 1'b1 || d_rdata !== 32'hAAAA_0001 || if_ack !== 1'b0) begin bad++; $display("FAIL prio_c2: d_ack/d_rdata/if_ack got %b/%h/%b want 1/aaaa0001/0", d_ack, d_rdata, if_ack); end
        d_read = 0; mem_rdata = 32'hBBBB_0002;
        tick();                                                           // cycle 3
        total++; if (d_ack !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL prio_c3: d_ack/mem_req got %b/%b want 0/0", d_ack, mem_req); end
        tick();                                                           // cycle 4
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin bad++; $display("FAIL prio_c4: req/addr got %b/%h want 1/00000044", mem_req, mem_addr); end
        tick();                                                           // cycle 5
        total++; if (if_ack !== 1'b1 || if_rdata !== 32'hBBBB_0002 || d_ack !== 1'b0) begin bad++; $display("FAIL prio_c5: if_ack/if_rdata/d_ack got %b/%h/%b want 1/bbbb0002/0", if_ack, if_rdata, d_ack); end
        if_req = 0; mem_ready = 0;
        tick();
    endtask

    // Store with three wait cycles.
    task automatic test_store();
        d_write = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        mem_ready = 0; mem_rdata = 32'h0000_0055;                          // cycle 0
        for (int c = 1; c <= 4; c++) begin
            tick();                                                       // cycles 1..4
            if (c == 4) mem_ready = 1;
            total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011) begin bad++; $display("FAIL store_c%0d: req/we/be got %b/%b/%h want 1/1/3", c, mem_req, mem_we, mem_be); end
            total++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_addr_c%0d: got %h/%h want 00000100/deadbeef", c, mem_addr, mem_wdata); end
            total++; if (stall !== 1'b1 || d_ack !== 1'b0) begin bad++; $display("FAIL store_stall_c%0d: stall/d_ack got %b/%b want 1/0", c, stall, d_ack); end
        end
        tick();                                                           // cycle 5
        mem_ready = 0;
        total++; if (d_ack !== 1'b1 || bus_err !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL store_ack: d_ack/bus_err/stall got %b/%b/%b want 1/0/0", d_ack, bus_err, stall); end
        d_write = 0;
        tick();
    endtask

    // No mem_ready at all: abort after 4 cycles in DATA.
    task automatic test_timeout();
        d_read = 1; d_addr = 32'h300; mem_ready = 0;                      // cycle 0
        for (int c = 1; c <= 4; c++) begin
            tick();
            total++; if (mem_req !== 1'b1 || d_ack !== 1'b0) begin bad++; $display("FAIL tmo_wait_c%0d: req/ack got %b/%b want 1/0", c, mem_req, d_ack); end
        end
        tick();                                                           // cycle 5
        total++; if (d_ack !== 1'b1 || bus_err !== 1'b1 || d_rdata !== 32'd0) begin bad++; $display("FAIL tmo_ack: ack/err/rdata got %b/%b/%h want 1/1/0", d_ack, bus_err, d_rdata); end
        d_read = 0;
        tick();
        total++; if (d_ack !== 1'b0 || bus_err !== 1'b0) begin bad++; $display("FAIL tmo_after: ack/err got %b/%b want 0/0", d_ack, bus_err); end
    endtask

    // Request held through its ack: one ack, no regrant during RESP.
    task automatic test_hold();
        int acks;
        acks = 0;
        if_req = 1; if_addr = 32'h80; mem_ready = 1; mem_rdata = 32'h1234_5678;
        tick(); if (if_ack) acks++;                                        // cycle 1
        tick(); if (if_ack) acks++;                                        // cycle 2 (RESP)
        tick();                                                            // cycle 3 (IDLE)
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hold_regrant: mem_req got %b want 0", mem_req); end
        if (if_ack) acks++;
        if_req = 0;
        for (int c = 0; c < 4; c++) begin tick(); if (if_ack) acks++; end
        mem_ready = 0;
        total++; if (acks !== 1) begin bad++; $display("FAIL hold_ack_count: got %0d want 1", acks); end
    endtask

    // Load withdrawn right after grant still completes.
    task automatic test_withdraw();
        d_read = 1; d_addr = 32'h400; mem_ready = 0; mem_rdata = 32'hCAFE_F00D;
        tick();                                                           // cycle 1
        d_read = 0;
        tick();                                                           // cycle 2
        mem_ready = 1;
        tick();                                                           // cycle 3
        mem_ready = 0;
        total++; if (d_ack !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL withdraw_ack: ack/rdata got %b/%h want 1/cafef00d", d_ack, d_rdata); end
        tick();
    endtask

    // Reset between edges during a fetch.
    task automatic test_reset_mid();
        int acks;
        acks = 0;
        if_req = 1; if_addr = 32'h88; mem_ready = 0;
        tick();                                                           // cycle 1, FETCH
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rmid_pre: mem_req got %b want 1", mem_req); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || mem_addr !== 32'd0) begin bad++; $display("FAIL rmid_async: req/addr got %b/%h want 0/0", mem_req, mem_addr); end
        mem_ready = 1;
        tick(); tick();
        if_req = 0;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin tick(); if (if_ack) acks++; end
        mem_ready = 0;
        total++; if (acks !== 0) begin bad++; $display("FAIL rmid_no_ack: got %0d acks want 0", acks); end
        test_fetch(32'h9ABC_DEF0);
    endtask

    initial begin
        test_reset();
        test_fetch(32'h0102_0304);
        test_priority();
        test_store();
        test_timeout();
        test_hold();
        test_withdraw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
